// File: rtl/rob_commit_scheduler_if.sv
// Dispatch / execute / retire bus of the ROB commit scheduler.
// Optional perf counters appear when ROB_PERF_CNT_EN is defined.
interface rob_commit_scheduler_if #(
    parameter int BUF_SIZE_LOG = 3
);
    logic [1:0]              alloc_req;
    logic [1:0]              alloc_grant;
    logic [BUF_SIZE_LOG-1:0] alloc_idx0;
    logic [BUF_SIZE_LOG-1:0] alloc_idx1;
    logic                    done_valid;
    logic [BUF_SIZE_LOG-1:0] done_idx;
    logic [1:0]              commit_valid;
    logic [BUF_SIZE_LOG-1:0] commit_idx0;
    logic [BUF_SIZE_LOG-1:0] commit_idx1;
    logic                    flush_valid;
    logic [BUF_SIZE_LOG-1:0] flush_idx;
    logic [BUF_SIZE_LOG:0]   count;
`ifdef ROB_PERF_CNT_EN
    logic [31:0]             perf_commit_cnt;
    logic [31:0]             perf_full_stall;

    modport master (
        output alloc_req, done_valid, done_idx, flush_valid, flush_idx,
        input  alloc_grant, alloc_idx0, alloc_idx1, commit_valid,
               commit_idx0, commit_idx1, count, perf_commit_cnt, perf_full_stall
    );
    modport slave (
        input  alloc_req, done_valid, done_idx, flush_valid, flush_idx,
        output alloc_grant, alloc_idx0, alloc_idx1, commit_valid,
               commit_idx0, commit_idx1, count, perf_commit_cnt, perf_full_stall
    );
`else
    modport master (
        output alloc_req, done_valid, done_idx, flush_valid, flush_idx,
        input  alloc_grant, alloc_idx0, alloc_idx1, commit_valid,
               commit_idx0, commit_idx1, count
    );
    modport slave (
        input  alloc_req, done_valid, done_idx, flush_valid, flush_idx,
        output alloc_grant, alloc_idx0, alloc_idx1, commit_valid,
               commit_idx0, commit_idx1, count
    );
`endif
endinterface

// File: rtl/rob_commit_scheduler.sv
// ROB sequencer: circular head/tail with wrap bit, per-entry FREE/ISSUED/EXECUTED,
// 2-wide in-order allocate, 2-wide in-order retire, partial squash on mispredict.
// Optional macro ROB_PERF_CNT_EN adds commit and full-stall perf counters.
module rob_commit_scheduler #(
    parameter int BUF_SIZE     = 8,
    parameter int BUF_SIZE_LOG = 3
) (
    input logic                   clk,
    input logic                   rst_n,
    rob_commit_scheduler_if.slave rob
);
    localparam int L = BUF_SIZE_LOG;
    localparam logic [L:0] SIZE_P = (L+1)'(BUF_SIZE);

    typedef enum logic [1:0] {ST_FREE, ST_ISSUED, ST_EXEC} ent_state_e;

    ent_state_e ent_st  [BUF_SIZE];
    ent_state_e st_nxt  [BUF_SIZE];
    logic [BUF_SIZE-1:0][L-1:0] ent_off;

    logic [L:0]   head, tail, cnt, head_nxt, tail_nxt;
    logic [L-1:0] hidx, tidx, off, done_off;
    logic         g0, g1, c0, c1, live, done_hit;

    assign cnt  = tail - head;
    assign hidx = head[L-1:0];
    assign tidx = tail[L-1:0];

    // Allocation grant from registered occupancy only; suppressed during a flush
    always_comb begin
        g0 = rob.alloc_req[0] && (cnt != SIZE_P) && !rob.flush_valid;
        g1 = rob.alloc_req[1] && g0 && (cnt <= SIZE_P - (L+1)'(2));
    end

    // Flush liveness and done filtering: a done aimed past the branch is dropped
    always_comb begin
        off      = rob.flush_idx - hidx;
        live     = rob.flush_valid && ({1'b0, off} < cnt);
        done_off = rob.done_idx - hidx;
        done_hit = rob.done_valid && (ent_st[rob.done_idx] == ST_ISSUED)
                   && !(live && (done_off > off));
    end

    // In-order retire; lane 1 is withheld if the same-cycle flush squashes it
    always_comb begin
        c0 = (cnt >= (L+1)'(1)) && (ent_st[hidx] == ST_EXEC);
        c1 = c0 && (cnt >= (L+1)'(2)) && (ent_st[hidx + 1'b1] == ST_EXEC)
             && !(live && (off == '0));
    end

    // Per-entry next state: squash, complete, retire, allocate
    always_comb begin
        st_nxt = ent_st;
        for (int i = 0; i < BUF_SIZE; i++) begin
            ent_off[i] = L'(i) - hidx;
            if (live && (ent_off[i] > off) && ({1'b0, ent_off[i]} < cnt))
                st_nxt[i] = ST_FREE;
        end
        if (done_hit) st_nxt[rob.done_idx] = ST_EXEC;
        if (c0) st_nxt[hidx] = ST_FREE;
        if (c1) st_nxt[hidx + 1'b1] = ST_FREE;
        if (g0) st_nxt[tidx] = ST_ISSUED;
        if (g1) st_nxt[tidx + 1'b1] = ST_ISSUED;
    end

    // Pointer update; a live flush rebuilds tail just past the branch
    always_comb begin
        head_nxt = head + (L+1)'(c0) + (L+1)'(c1);
        if (live) tail_nxt = head + {1'b0, off} + (L+1)'(1);
        else      tail_nxt = tail + (L+1)'(g0) + (L+1)'(g1);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            for (int i = 0; i < BUF_SIZE; i++) ent_st[i] <= ST_FREE;
        end else begin
            head   <= head_nxt;
            tail   <= tail_nxt;
            ent_st <= st_nxt;
        end
    end

    assign rob.alloc_grant  = {g1, g0};
    assign rob.alloc_idx0   = tidx;
    assign rob.alloc_idx1   = tidx + 1'b1;
    assign rob.commit_valid = {c1, c0};
    assign rob.commit_idx0  = hidx;
    assign rob.commit_idx1  = hidx + 1'b1;
    assign rob.count        = cnt;

`ifdef ROB_PERF_CNT_EN
    logic [31:0] perf_commit, perf_stall;

    // Retired-entry and full-stall counters; flush does not touch them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_commit <= '0;
            perf_stall  <= '0;
        end else begin
            perf_commit <= perf_commit + 32'(c0) + 32'(c1);
            if (rob.alloc_req[0] && (cnt == SIZE_P)) perf_stall <= perf_stall + 32'd1;
        end
    end

    assign rob.perf_commit_cnt = perf_commit;
    assign rob.perf_full_stall = perf_stall;
`endif
endmodule

// File: tb/tb_rob_commit_scheduler.sv
// Bench for rob_commit_scheduler: queue-based ROB model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rob_commit_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rob_commit_scheduler_if #(.BUF_SIZE_LOG(3)) bus();

    rob_commit_scheduler #(.BUF_SIZE(8), .BUF_SIZE_LOG(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rob   (bus.slave)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input longint got, input longint exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    endtask

    // Live entries oldest first; head is the ring index of q[0]
    typedef struct {
        logic [2:0] idx;
        bit         done;
    } ent_t;
    ent_t   q[$];
    int     mhead;
    int     ncommit;
    longint mpc, mps;

    // Model: predict this cycle's outputs, compare, then advance to next cycle
    always @(negedge clk) begin
        int sz, tl, off, eg, ec, n;
        bit eg0, eg1, ec0, ec1, live;
        if (!rst_n) begin
            q.delete();
            mhead = 0; ncommit = 0; mpc = 0; mps = 0;
        end else begin
            sz   = q.size();
            tl   = (mhead + sz) % 8;
            eg0  = bus.alloc_req[0] && sz < 8 && !bus.flush_valid;
            eg1  = bus.alloc_req[1] && eg0 && sz <= 6;
            off  = (int'(bus.flush_idx) - mhead + 8) % 8;
            live = bus.flush_valid && off < sz;
            ec0  = sz >= 1 && q[0].done;
            ec1  = ec0 && sz >= 2 && q[1].done && !(live && off == 0);
            eg   = int'(eg0) + 2 * int'(eg1);
            ec   = int'(ec0) + 2 * int'(ec1);
            chk("m_grant", bus.alloc_grant, eg);
            chk("m_aidx0", bus.alloc_idx0, tl);
            chk("m_aidx1", bus.alloc_idx1, (tl + 1) % 8);
            chk("m_cvalid", bus.commit_valid, ec);
            chk("m_cidx0", bus.commit_idx0, mhead);
            chk("m_cidx1", bus.commit_idx1, (mhead + 1) % 8);
            chk("m_count", bus.count, sz);
            chk("m_count_le_8", longint'(bus.count <= 8), 1);
`ifdef ROB_PERF_CNT_EN
            chk("m_perf_commit", bus.perf_commit_cnt, mpc);
            chk("m_perf_stall", bus.perf_full_stall, mps);
`endif
            if (bus.alloc_req[0] && sz == 8) mps = (mps + 1) % 64'h1_0000_0000;
            if (bus.done_valid)
                for (int p = 0; p < sz; p++)
                    if (q[p].idx == bus.done_idx && !(live && p > off)) q[p].done = 1'b1;
            if (live) while (q.size() > off + 1) void'(q.pop_back());
            n = int'(ec0) + int'(ec1);
            for (int k = 0; k < n; k++) void'(q.pop_front());
            mhead   = (mhead + n) % 8;
            ncommit += n;
            mpc     = (mpc + n) % 64'h1_0000_0000;
            if (eg0) q.push_back('{idx: 3'(tl), done: 1'b0});
            if (eg1) q.push_back('{idx: 3'((tl + 1) % 8), done: 1'b0});
        end
    end

    task automatic cyc(); @(posedge clk); #1; endtask
    task automatic mid(); @(negedge clk); #1; endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        bus.alloc_req = 2'b00; bus.done_valid = 1'b0; bus.done_idx = '0;
        bus.flush_valid = 1'b0; bus.flush_idx = '0;
        #2;
        chk("rst_count", bus.count, 0);
        chk("rst_grant", bus.alloc_grant, 0);
        chk("rst_cvalid", bus.commit_valid, 0);
        chk("rst_aidx1", bus.alloc_idx1, 1);
        cyc(); cyc();
        rst_n = 1'b1;

        // Fill: four double grants, then stall three cycles while full
        bus.alloc_req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("fill_grant", bus.alloc_grant, 3);
            chk("fill_idx0", bus.alloc_idx0, 2 * i);
            chk("fill_idx1", bus.alloc_idx1, 2 * i + 1);
            cyc();
        end
        mid();
        chk("full_grant", bus.alloc_grant, 0);
        chk("full_count", bus.count, 8);
        cyc(); cyc(); cyc();
        bus.alloc_req = 2'b00;
`ifdef ROB_PERF_CNT_EN
        mid();
        chk("perf_stall3", bus.perf_full_stall, 3);
        cyc();
`endif

        // Out-of-order completion, then double retire
        bus.done_valid = 1'b1; bus.done_idx = 3'd1; cyc();
        bus.done_idx = 3'd0; cyc();
        bus.done_valid = 1'b0;
        mid();
        chk("dbl_cvalid", bus.commit_valid, 3);
        chk("dbl_cidx0", bus.commit_idx0, 0);
        chk("dbl_cidx1", bus.commit_idx1, 1);
        cyc();
        mid();
        chk("dbl_count", bus.count, 6);
        cyc();

        // Async reset with live entries, then single retire blocked by older lane
        rst_n = 1'b0; #1;
        chk("async_rst_count", bus.count, 0);
        chk("async_rst_cvalid", bus.commit_valid, 0);
        cyc(); rst_n = 1'b1;
        bus.alloc_req = 2'b11; cyc();
        bus.alloc_req = 2'b00;
        bus.done_valid = 1'b1; bus.done_idx = 3'd0; cyc();
        bus.done_valid = 1'b0;
        mid();
        chk("single_cvalid", bus.commit_valid, 1);
        chk("single_cidx0", bus.commit_idx0, 0);
        cyc();
        mid();
        chk("single_after", bus.commit_valid, 0);
        chk("single_head", bus.commit_idx0, 1);
        chk("single_count", bus.count, 1);
        cyc(); cyc();
        bus.done_valid = 1'b1; bus.done_idx = 3'd1; cyc();
        bus.done_valid = 1'b0;
        mid();
        chk("single_e1", bus.commit_valid, 1);
        chk("single_e1_idx", bus.commit_idx0, 1);
        cyc();

        // Flush: head=2, count=6, branch at 4; done on squashed entry 6 dropped
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        bus.alloc_req = 2'b11;
        repeat (4) cyc();
        bus.alloc_req = 2'b00;
        bus.done_valid = 1'b1; bus.done_idx = 3'd1; cyc();
        bus.done_idx = 3'd0; cyc();
        bus.done_valid = 1'b0; cyc();
        mid();
        chk("pre_flush_count", bus.count, 6);
        chk("pre_flush_head", bus.commit_idx0, 2);
        cyc();
        bus.flush_valid = 1'b1; bus.flush_idx = 3'd4;
        bus.done_valid = 1'b1; bus.done_idx = 3'd6;
        bus.alloc_req = 2'b11;
        mid();
        chk("flush_grant", bus.alloc_grant, 0);
        cyc();
        bus.flush_valid = 1'b0; bus.done_valid = 1'b0; bus.alloc_req = 2'b01;
        mid();
        chk("flush_count", bus.count, 3);
        chk("flush_aidx0", bus.alloc_idx0, 5);
        chk("flush_grant_after", bus.alloc_grant, 1);
        cyc();
        cyc();
        bus.alloc_req = 2'b00;
        bus.done_valid = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            bus.done_idx = 3'(k);
            cyc();
        end
        bus.done_valid = 1'b0;
        cyc(); cyc(); cyc();
        mid();
        chk("drain_count", bus.count, 1);
        chk("drain_cvalid", bus.commit_valid, 0);
        cyc();

        // Three full ring wraps under continuous traffic
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        c = 0;
        while (ncommit < 26 && c < 300) begin
            bus.alloc_req = 2'b11;
            bus.done_valid = 1'b1;
            bus.done_idx = 3'(c % 8);
            cyc();
            c++;
        end
        bus.alloc_req = 2'b00; bus.done_valid = 1'b0;
        chk("wrap_commits_reached", longint'(ncommit >= 26), 1);
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
